// File: rtl/wait_state_ram.sv
// Single-port word RAM with a fixed number of wait states before each one-cycle response.
// Requests are captured in IDLE; a write lands on the edge that ends RESP, and read data is registered into RESP.
module wait_state_ram #(
    parameter int ADDR_WIDTH  = 32,
    parameter int WORD_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [WORD_WIDTH-1:0] wdata_i,
    input  logic [3:0]            we_i,
    output logic [WORD_WIDTH-1:0] rdata_o,
    output logic [31:0]           xfer_count_o
);

    localparam int         IDX_W     = $clog2(DEPTH_WORDS);
    localparam int         LANE_W    = WORD_WIDTH / 4;
    localparam bit         HAS_WAIT  = (WAIT_CYCLES > 0);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                 state_reg;
    state_t                 state_next;
    logic [3:0]             wait_cnt_reg;
    logic [3:0]             wait_cnt_next;
    logic [IDX_W-1:0]       idx_reg;
    logic [WORD_WIDTH-1:0]  wdata_reg;
    logic [3:0]             we_reg;
    logic [31:0]            count_reg;

    logic                   accept;
    logic                   rd_en;
    logic                   wr_en;
    logic [IDX_W-1:0]       rd_idx;
    logic [IDX_W-1:0]       addr_idx;

    // Byte offset and bits above the array size only alias, they never select storage.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_i[1:0], addr_i[ADDR_WIDTH-1:IDX_W+2]};

    assign addr_idx = addr_i[IDX_W+1:2];
    assign accept   = (state_reg == ST_IDLE) && valid_i;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (valid_i) begin
                    state_next = HAS_WAIT ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_reg <= 4'd1) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        ready_o = (state_reg == ST_RESP);
        wr_en   = (state_reg == ST_RESP) && (we_reg != 4'b0000);
        rd_idx  = (state_reg == ST_IDLE) ? addr_idx : idx_reg;
        // Read data is loaded on the edge entering RESP; with no wait states that is the accept edge itself.
        rd_en   = (state_next == ST_RESP) && (state_reg != ST_RESP) &&
                  (((state_reg == ST_IDLE) && (we_i == 4'b0000)) ||
                   ((state_reg == ST_WAIT) && (we_reg == 4'b0000)));
    end

    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (accept && HAS_WAIT) begin
            wait_cnt_next = WAIT_LOAD;
        end else if ((state_reg == ST_WAIT) && (wait_cnt_reg != 4'd0)) begin
            wait_cnt_next = wait_cnt_reg - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt_reg <= 4'd0;
            idx_reg      <= '0;
            wdata_reg    <= '0;
            we_reg       <= 4'b0000;
            count_reg    <= 32'd0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
            if (accept) begin
                idx_reg   <= addr_idx;
                wdata_reg <= wdata_i;
                we_reg    <= we_i;
            end
            if (state_reg == ST_RESP) begin
                count_reg <= count_reg + 32'd1;
            end
        end
    end

    assign xfer_count_o = count_reg;

    // One narrow array per byte lane keeps lane enables simple and maps onto block RAM.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi = gi + 1) begin : g_lane
            logic [LANE_W-1:0] mem_lane [DEPTH_WORDS];
            logic [LANE_W-1:0] rd_lane_reg;

            always_ff @(posedge clk) begin
                if (rst_n && wr_en && we_reg[gi]) begin
                    mem_lane[idx_reg] <= wdata_reg[gi*LANE_W +: LANE_W];
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rd_lane_reg <= '0;
                end else if (rd_en) begin
                    rd_lane_reg <= mem_lane[rd_idx];
                end
            end

            assign rdata_o[gi*LANE_W +: LANE_W] = rd_lane_reg;
        end
    endgenerate

endmodule

// File: tb/tb_wait_state_ram.sv
// Self-checking bench: a reference memory predicts each response, expectations are queued at drive
// time and popped when ready_o pulses. A second instance covers the zero-wait-state configuration.
module tb_wait_state_ram;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        valid, ready;
    logic [31:0] addr, wdata, rdata, count;
    logic [3:0]  we;

    logic        valid0, ready0;
    logic [31:0] addr0, wdata0, rdata0, count0;
    logic [3:0]  we0;

    wait_state_ram #(
        .ADDR_WIDTH(32), .WORD_WIDTH(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid), .ready_o(ready),
        .addr_i(addr), .wdata_i(wdata), .we_i(we), .rdata_o(rdata),
        .xfer_count_o(count)
    );

    wait_state_ram #(
        .ADDR_WIDTH(32), .WORD_WIDTH(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .valid_i(valid0), .ready_o(ready0),
        .addr_i(addr0), .wdata_i(wdata0), .we_i(we0), .rdata_o(rdata0),
        .xfer_count_o(count0)
    );

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] model_mem [int];
    logic [31:0] exp_q [$];
    logic [31:0] hold_rdata = 32'h0;
    int unsigned exp_cnt = 0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
        end
        return r;
    endfunction

    // One transaction on the WAIT_CYCLES=2 instance; entered and left on a negedge with the DUT idle.
    task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                        input bit garble, input string name);
        int          idx;
        int          lat;
        bit          seen;
        logic [31:0] old, e;
        idx = int'(a[11:2]);
        old = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
        if (be == 4'b0000) begin
            e = old;
            hold_rdata = old;
        end else begin
            e = hold_rdata;
            model_mem[idx] = merge(old, d, be);
        end
        exp_q.push_back(e);
        exp_cnt++;

        valid = 1'b1; addr = a; wdata = d; we = be;
        @(posedge clk); #1;
        if (garble) begin
            addr = $urandom; wdata = $urandom; we = 4'($urandom);
        end else begin
            valid = 1'b0;
        end

        seen = 1'b0; lat = 0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                seen = 1'b1; lat = k;
            end
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL %s_timeout: ready_o not seen within 20 cycles", name);
            void'(exp_q.pop_front());
            valid = 1'b0;
            return;
        end
        e = exp_q.pop_front();
        tests_run++;
        if (lat != 3) begin
            tests_failed++;
            $display("FAIL %s_latency: got %0d cycles, expected 3", name, lat);
        end
        tests_run++;
        if (rdata !== e) begin
            tests_failed++;
            $display("FAIL %s_rdata: got %08h, expected %08h", name, rdata, e);
        end

        @(negedge clk);
        valid = 1'b0;
        tests_run++;
        if (ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_pulse_width: ready_o=%b after RESP, expected 0", name, ready);
        end
        tests_run++;
        if (count !== 32'(exp_cnt)) begin
            tests_failed++;
            $display("FAIL %s_count: got %0d, expected %0d", name, count, exp_cnt);
        end
        tests_run++;
        if (rdata !== e) begin
            tests_failed++;
            $display("FAIL %s_rdata_hold: got %08h, expected %08h", name, rdata, e);
        end
        $display("[TB] %s addr=%08h we=%b wdata=%08h rdata=%08h lat=%0d count=%0d",
                 name, a, be, d, rdata, lat, count);
    endtask

    task automatic check_word(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %08h, expected %08h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        valid = 1'b0; addr = 32'h0; wdata = 32'h0; we = 4'b0;
        valid0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0; we0 = 4'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_word("reset_ready", {31'b0, ready}, 32'h0);
        check_word("reset_rdata", rdata, 32'h0);
        check_word("reset_count", count, 32'h0);
        check_word("reset_ready0", {31'b0, ready0}, 32'h0);
        check_word("reset_count0", count0, 32'h0);
        rst_n = 1'b1;
        exp_cnt = 0;
        hold_rdata = 32'h0;
        $display("[TB] reset released");
    endtask

    task automatic test_write_read();
        xfer(32'h10, 32'hDEADBEEF, 4'b1111, 1'b0, "wr_full");
        check_word("wr_full_count_one", count, 32'd1);
        xfer(32'h10, 32'h0, 4'b0000, 1'b0, "rd_full");
        check_word("rd_full_value", rdata, 32'hDEADBEEF);
        repeat (3) @(negedge clk);
        check_word("rd_full_hold", rdata, 32'hDEADBEEF);
    endtask

    task automatic test_byte_lanes();
        xfer(32'h10, 32'h11223344, 4'b0101, 1'b0, "wr_lanes");
        check_word("wr_lanes_rdata_unchanged", rdata, 32'hDEADBEEF);
        xfer(32'h10, 32'h0, 4'b0000, 1'b0, "rd_lanes");
        check_word("rd_lanes_value", rdata, 32'hDE22BE44);
    endtask

    task automatic test_alias();
        xfer(32'h13, 32'h0, 4'b0000, 1'b0, "rd_alias_low");
        check_word("rd_alias_low_value", rdata, 32'hDE22BE44);
        xfer(32'h10 + DEPTH * 4, 32'h0, 4'b0000, 1'b0, "rd_alias_wrap");
        check_word("rd_alias_wrap_value", rdata, 32'hDE22BE44);
    endtask

    // Inputs are scrambled (valid held high) after each accept to prove captured values are used.
    task automatic test_back_to_back();
        int i;
        for (int n = 0; n < 8; n++) begin
            xfer(32'h100 + 32'(n * 4), $urandom, 4'b1111, 1'b1, "b2b_init");
        end
        for (int n = 0; n < 16; n++) begin
            i = $urandom_range(0, 7);
            if ($urandom_range(0, 1) == 0) begin
                xfer(32'h100 + 32'(i * 4), 32'h0, 4'b0000, 1'b1, "b2b_rd");
            end else begin
                xfer(32'h100 + 32'(i * 4), $urandom, 4'($urandom_range(1, 15)), 1'b1, "b2b_wr");
            end
        end
        for (int n = 0; n < 8; n++) begin
            xfer(32'h100 + 32'(n * 4), 32'h0, 4'b0000, 1'b1, "b2b_final_rd");
        end
    endtask

    task automatic test_reset_abort();
        bit pulse_seen;
        bit seen;
        xfer(32'h20, 32'h0BADCAFE, 4'b1111, 1'b0, "abort_pre_wr");

        valid = 1'b1; addr = 32'h20; wdata = 32'hCAFEF00D; we = 4'b1111;
        @(posedge clk); #1;
        valid = 1'b0;
        @(negedge clk);
        pulse_seen = (ready === 1'b1);
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (ready !== 1'b0) pulse_seen = 1'b1;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (ready !== 1'b0) pulse_seen = 1'b1;
        end
        check_word("abort_wait_no_pulse", {31'b0, pulse_seen}, 32'h0);
        check_word("abort_wait_count", count, 32'h0);
        check_word("abort_wait_rdata", rdata, 32'h0);
        exp_cnt = 0;
        hold_rdata = 32'h0;
        $display("[TB] reset during WAIT issued");
        xfer(32'h20, 32'h0, 4'b0000, 1'b0, "abort_wait_rd");
        check_word("abort_wait_mem", rdata, 32'h0BADCAFE);

        valid = 1'b1; addr = 32'h20; wdata = 32'h12345678; we = 4'b1111;
        @(posedge clk); #1;
        valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (ready === 1'b1) seen = 1'b1;
        end
        check_word("abort_resp_reached", {31'b0, seen}, 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_word("abort_resp_count", count, 32'h0);
        exp_cnt = 0;
        hold_rdata = 32'h0;
        $display("[TB] reset during RESP issued");
        xfer(32'h20, 32'h0, 4'b0000, 1'b0, "abort_resp_rd");
        check_word("abort_resp_mem", rdata, 32'h0BADCAFE);
    endtask

    // Zero wait states, valid held high: RESP on odd cycles, count advances after each pulse.
    task automatic test_zero_wait();
        valid0 = 1'b1; addr0 = 32'h30; wdata0 = 32'hA5A50000; we0 = 4'b1111;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check_word("zw_ready", {31'b0, ready0}, 32'(k % 2));
            check_word("zw_count", count0, 32'(k / 2));
            $display("[TB] zero_wait cycle=%0d ready=%b count=%0d", k, ready0, count0);
        end
        check_word("zw_rdata_untouched", rdata0, 32'h0);
        we0 = 4'b0000;
        @(negedge clk);
        valid0 = 1'b0;
        check_word("zw_rd_ready", {31'b0, ready0}, 32'h1);
        check_word("zw_rd_value", rdata0, 32'hA5A50000);
        @(negedge clk);
        check_word("zw_rd_pulse_width", {31'b0, ready0}, 32'h0);
        check_word("zw_rd_count", count0, 32'd7);
        $display("[TB] zero_wait read rdata=%08h count=%0d", rdata0, count0);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_alias();
        test_back_to_back();
        test_reset_abort();
        test_zero_wait();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wait_state_ram.md
WAIT_STATE_RAM -- requirements
Module: wait_state_ram

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-002 SHALL have parameter WORD_WIDTH, default 32, data word width.
REQ-003 SHALL have parameter DEPTH_WORDS, default 1024, power of two, storage size in words.
REQ-004 SHALL have parameter WAIT_CYCLES, default 2, range 0..15, wait states inserted before each response.
REQ-005 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset; synchronous and active-low.
REQ-007 SHALL have port valid_i  input  1  request valid from initiator.
REQ-008 SHALL have port ready_o  output  1  one-cycle completion pulse.
REQ-009 SHALL have port addr_i  input  ADDR_WIDTH  byte address.
REQ-010 SHALL have port wdata_i  input  WORD_WIDTH  write data.
REQ-011 SHALL have port we_i  input  4  byte-lane write enables; 4'b0000 = read.
REQ-012 SHALL have port rdata_o  output  WORD_WIDTH  read data, valid while ready_o=1.
REQ-013 SHALL have port xfer_count_o  output  32  count of completed transactions.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-015 IDLE: valid_i=1 SHALL capture addr_i, wdata_i, we_i into internal registers; next state WAIT if WAIT_CYCLES>0, else RESP.
REQ-016 WAIT: SHALL load a down-counter with WAIT_CYCLES on entry and stay until WAITS elapsed, then go to RESP; WAIT lasts exactly WAIT_CYCLES cycles.
REQ-017 RESP: ready_o SHALL be 1 for exactly this one cycle; next state IDLE unconditionally.
REQ-018 Latency from acceptance edge to ready_o high SHALL be WAIT_CYCLES+1 cycles; minimum request spacing WAIT_CYCLES+2 cycles.
REQ-019 valid_i during RESP SHALL NOT start a new transaction; new request accepted only in IDLE.
REQ-020 Input changes after acceptance SHALL be ignored; transaction uses captured values.
REQ-021 valid_i dropping during WAIT SHALL NOT abort; transaction completes normally.
REQ-022 Word index SHALL be captured addr[log2(DEPTH_WORDS)+1:2]; addr[1:0] and upper bits ignored (addresses alias modulo DEPTH_WORDS*4).
REQ-023 Write (we nonzero) SHALL update only enabled byte lanes at the clock edge ending RESP; disabled lanes retain contents.
REQ-024 Read SHALL drive rdata_o with the addressed word during RESP; rdata_o SHALL hold its last read value otherwise and SHALL NOT change on write transactions.
REQ-025 Read following write to same word SHALL return the written data.
REQ-026 xfer_count_o SHALL increment by 1 on each RESP cycle, wrapping 0xFFFFFFFF->0.
REQ-027 ready_o SHALL be registered (state-decoded from flops), with no combinational path from any input.

Reset
REQ-028 rst_n=0 at a rising edge SHALL force state IDLE, ready_o=0, rdata_o=0, xfer_count_o=0, wait counter=0.
REQ-029 Reset during WAIT or RESP SHALL discard the pending transaction; pending write SHALL NOT modify memory.
REQ-030 Memory array contents SHALL NOT be cleared by reset.
REQ-031 First request SHALL be accepted in the first cycle with rst_n=1 and state IDLE.

Verification
REQ-032 WAIT_CYCLES=2: write addr 0x10, wdata 0xDEADBEEF, we 4'b1111 accepted cycle N -> ready_o=1 only in cycle N+3, xfer_count_o=1.
REQ-033 Then read addr 0x10 -> rdata_o=0xDEADBEEF with ready_o, 3 cycles after acceptance; rdata_o unchanged afterward.
REQ-034 Write 0x11223344 we 4'b0101 to word holding 0xDEADBEEF -> subsequent read returns 0xDE22BE44.
REQ-035 Read addr 0x13 and addr 0x10+DEPTH_WORDS*4 -> both return word at 0x10.
REQ-036 Assert rst_n=0 during WAIT of write 0xCAFEF00D to 0x20 -> ready_o never pulses, read of 0x20 returns prior contents, xfer_count_o=0 after reset.
REQ-037 WAIT_CYCLES=0, valid_i held high continuously -> ready_o pulses every 2 cycles, xfer_count_o increments per pulse.
